alu_iter: RTL
=============

Name: alu_iter

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Executes all RV32I/RV64I integer ALU ops with a registered result.
- Adds the RISC-V M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) as an iterative shift-add / restoring-divide engine.
- Sits in the execute stage; the core stalls on in_ready/out_valid.

Parameters:
- XLEN, 32: operand/result width; legal values 32 or 64.
- SHW, $clog2(XLEN): shift-amount width; derived, not overridden.
- OPW, 5: width of op select.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation
- op  in  OPW  operation select (encodings in shared package)
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2 or immediate)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  result
- illegal  out  1  qualified by out_valid; op was unsupported

Behaviour:
- Reset: async on rst_n low. State=IDLE, in_ready=1, out_valid=0, result=0, illegal=0, iteration counter=0.
- FSM states IDLE, BUSY, DONE.
- IDLE: in_ready=1. An op is accepted when in_valid&&in_ready; a, b and op are latched.
  - Base op: goes to DONE next cycle (latency 1).
  - M op: goes to BUSY and loads the counter with XLEN.
- BUSY: in_ready=0. One bit is processed per cycle and the counter decrements. At counter==1 the next state is DONE. M-op latency is XLEN+1 cycles from accept to out_valid.
- DONE: out_valid=1. result and illegal are held stable until out_ready. On out_ready, return to IDLE. No accept in DONE (in_ready=0); no back-to-back bypass.
- Base ops:
  - ADD and SUB wrap modulo 2^XLEN.
  - XOR, OR, AND.
  - SLL, SRL, SRA: shift amount is b[SHW-1:0] only; SRA is an arithmetic shift of signed a.
  - SLT is signed; SLTU is unsigned; result is 1 or 0, zero-extended.
  - Immediate forms share encodings with their register forms; the decoder passes the sign-extended immediate on b.
- Multiply:
  - Operands are converted to magnitude with sign tracking per MULH (s×s), MULHSU (s×u), MULHU (u×u).
  - The 2·XLEN product is negated at the end if the signs differ.
  - MUL returns the low half; the other three return the high half.
- Divide (restoring):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return a. The full XLEN cycles still elapse, so latency is fixed.
  - Signed overflow (a=most-negative, b=-1): DIV returns a; REM returns 0.
  - Remainder sign follows the dividend.
- Undefined op encoding: goes to DONE with result=0 and illegal=1.
- Reset mid-BUSY aborts the operation with no output. in_valid while busy is ignored (not queued).

Optional Feature:
- Macro ALU_ITER_MULDIV_EN.
- Defined: M ops execute as above.
- Undefined: the BUSY state, counter and datapath are compiled out. M-op encodings are treated as undefined: 1-cycle DONE, result=0, illegal=1.

Decomposition:
- Shared package (defines include) holds:
  - op encodings: ALU_ADD..ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  - FSM state constants
- Sub-module alu_iter_muldiv holds the shift-add/restoring engine, with start/done/counter; it is instantiated only under ALU_ITER_MULDIV_EN.
- The base-op combinational case stays in the top module.

Test Plan:
- SRA: XLEN=32, op=SRA, a=0x8000_0000, b=0x0000_0024 (shift 4) → result 0xF800_0000 one cycle after accept; in_ready low until out_ready.
- SLT vs SLTU: a=0xFFFF_FFFF, b=1 → SLT=1, SLTU=0.
- MULH: a=0xFFFF_FFFE, b=3 → result 0xFFFF_FFFF. MUL with the same operands → 0xFFFF_FFFA. out_valid exactly 33 cycles after accept.
- DIV: a=7, b=0 → 0xFFFF_FFFF; REM → 7. DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM → 0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: result stable, in_valid ignored.
  - Assert rst_n low in BUSY cycle 10: out_valid=0 and in_ready=1 immediately after reset, with no stale result.
- Macro off: MUL request → 1-cycle DONE, result=0, illegal=1; ADD still correct.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// Shared op encodings, FSM state type and op-class helper for alu_iter.
package alu_iter_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_XOR    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_AND    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  // M ops occupy 16..23 so the low three bits select the variant
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

  function automatic logic is_mop(input logic [4:0] o);
    return o[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle after a
// one-cycle sign/magnitude prep step. op[2]=divide, op[1:0]=variant.
module alu_iter_muldiv
  #(parameter int XLEN = 32)
  (input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            last,
   output logic [XLEN-1:0] res);

  localparam int CW = $clog2(XLEN+1);

  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r, b_r, dv, ma, mb, q, r;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [CW-1:0]     cnt;
  logic              run, prep, sa, neg, b0, sgn_a, sgn_b, is_div;
  logic [XLEN:0]     sum, rs, diff;
  logic [XLEN-1:0]   fin;

  assign is_div = op_r[2];
  assign last   = run & ~prep & (cnt == CW'(1));

  always_comb begin
    sgn_a = a_r[XLEN-1] & (is_div ? ~op_r[0] : (op_r[1:0] != 2'b11));
    sgn_b = b_r[XLEN-1] & (is_div ? ~op_r[0] : ~op_r[1]);
    ma    = sgn_a ? -a_r : a_r;
    mb    = sgn_b ? -b_r : b_r;
  end

  // acc = {partial product hi, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dv} : '0);
    rs   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = rs - {1'b0, dv};
    if (!is_div)
      acc_nxt = {sum, acc[XLEN-1:1]};
    else if (rs >= {1'b0, dv})
      acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    prod = neg ? -acc_nxt : acc_nxt;
    q    = acc_nxt[XLEN-1:0];
    r    = acc_nxt[2*XLEN-1:XLEN];
    if (!is_div)
      fin = (op_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_r[1])
      fin = b0 ? a_r : (sa ? -r : r);
    else
      fin = b0 ? '1 : (neg ? -q : q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= '0; a_r <= '0; b_r <= '0; dv <= '0; acc <= '0; cnt <= '0;
      run  <= 1'b0; prep <= 1'b0; sa <= 1'b0; neg <= 1'b0; b0 <= 1'b0; res <= '0;
    end else if (start) begin
      op_r <= op; a_r <= a; b_r <= b;
      run  <= 1'b1; prep <= 1'b1; cnt <= CW'(XLEN);
    end else if (run && prep) begin
      prep <= 1'b0;
      sa   <= sgn_a;
      neg  <= sgn_a ^ sgn_b;
      b0   <= (b_r == '0);
      dv   <= is_div ? mb : ma;
      acc  <= {{XLEN{1'b0}}, (is_div ? ma : mb)};
    end else if (run) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        run <= 1'b0;
        res <= fin;
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked execute-stage ALU: 1-cycle base ops, iterative M ops when
// ALU_ITER_MULDIV_EN is defined (otherwise M encodings report illegal).
module alu_iter
  import alu_iter_pkg::*;
  #(parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN),
    parameter int OPW  = 5)
  (input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal);

  state_t          state, nstate;
  logic [XLEN-1:0] base_res, result_q, md_res;
  logic            base_ok, illegal_q, use_md, mop_ok, md_last;

  always_comb begin
    base_res = '0;
    base_ok  = 1'b1;
    case (op)
      ALU_ADD:  base_res = a + b;
      ALU_SUB:  base_res = a - b;
      ALU_XOR:  base_res = a ^ b;
      ALU_OR:   base_res = a | b;
      ALU_AND:  base_res = a & b;
      ALU_SLL:  base_res = a << b[SHW-1:0];
      ALU_SRL:  base_res = a >> b[SHW-1:0];
      ALU_SRA:  base_res = $signed(a) >>> b[SHW-1:0];
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
      default:  base_ok  = 1'b0;
    endcase
  end

`ifdef ALU_ITER_MULDIV_EN
  logic md_start;
  assign mop_ok   = is_mop(op);
  assign md_start = (state == ST_IDLE) & in_valid & mop_ok;

  alu_iter_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (op[2:0]),
    .a     (a),
    .b     (b),
    .last  (md_last),
    .res   (md_res));
`else
  assign mop_ok  = 1'b0;
  assign md_last = 1'b0;
  assign md_res  = '0;
`endif

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (in_valid) nstate = mop_ok ? ST_BUSY : ST_DONE;
`ifdef ALU_ITER_MULDIV_EN
      ST_BUSY: if (md_last) nstate = ST_DONE;
`endif
      ST_DONE: if (out_ready) nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      use_md    <= 1'b0;
    end else begin
      state <= nstate;
      if (state == ST_IDLE && in_valid) begin
        result_q  <= base_res;
        illegal_q <= ~(base_ok | mop_ok);
        use_md    <= mop_ok;
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = use_md ? md_res : result_q;
  assign illegal   = illegal_q;

endmodule
